dataflow_perf_monitor: RTL and testbench

DATAFLOW_PERF_MONITOR -- requirements
Module: dataflow_perf_monitor

---
 rtl/dataflow_perf_monitor.sv | 182 ++++++++++++++++++
 tb/tb_dataflow_perf_monitor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dataflow_perf_monitor.sv
// dataflow_perf_monitor
//   Observes NUM_CH ap_ctrl handshakes and keeps per-channel statistics:
//   start/done/busy/stall/iteration counts plus last and max run latency.
//   All counters saturate at all-ones. Statistics can be frozen (finish)
//   and cleared (clear). A registered readout port returns one field per read.
//
// Ports
//   clock, reset           : rising-edge clock, async active-high reset
//   finish                 : freeze statistics from the next cycle on
//   clear                  : synchronous clear of statistics, FSMs and frozen
//   ap_start/ap_ready/ap_done/ap_continue/iter_end [NUM_CH] : monitored handshakes
//   rd_en, rd_ch, rd_field : readout request, channel and field select
//   rd_data, rd_valid      : registered readout value and its valid flag
//   frozen                 : statistics are frozen
//   ch_state [2*NUM_CH]    : per-channel FSM state, channel n at [2n+1:2n]
module dataflow_perf_monitor #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  finish,
  input  logic                  clear,
  input  logic [NUM_CH-1:0]     ap_start,
  input  logic [NUM_CH-1:0]     ap_ready,
  input  logic [NUM_CH-1:0]     ap_done,
  input  logic [NUM_CH-1:0]     ap_continue,
  input  logic [NUM_CH-1:0]     iter_end,
  input  logic                  rd_en,
  input  logic [CH_W-1:0]       rd_ch,
  input  logic [2:0]            rd_field,
  output logic [CNT_W-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  frozen,
  output logic [2*NUM_CH-1:0]   ch_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    BUSY      = 2'b01,
    WAIT_CONT = 2'b10
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Per-channel statistics gathered for the readout mux.
  logic [CNT_W-1:0] f_start [NUM_CH];
  logic [CNT_W-1:0] f_done  [NUM_CH];
  logic [CNT_W-1:0] f_busy  [NUM_CH];
  logic [CNT_W-1:0] f_stall [NUM_CH];
  logic [CNT_W-1:0] f_iter  [NUM_CH];
  logic [CNT_W-1:0] f_max   [NUM_CH];
  logic [CNT_W-1:0] f_last  [NUM_CH];
  logic [1:0]       f_state [NUM_CH];
  logic             f_err   [NUM_CH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       frozen <= 1'b0;
    else if (clear)  frozen <= 1'b0;
    else if (finish) frozen <= 1'b1;
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    state_t           state, state_nxt;
    logic             capture;
    logic [CNT_W-1:0] lat_cnt, lat_inc;
    logic [CNT_W-1:0] start_cnt, done_cnt, busy_cnt, stall_cnt, iter_cnt;
    logic [CNT_W-1:0] max_lat, last_lat;
    logic             err;

    assign lat_inc = sat_inc(lat_cnt);

    always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
        IDLE: if (ap_start[n]) state_nxt = BUSY;
        BUSY: begin
          if (ap_done[n]) begin
            capture = 1'b1;
            if (!ap_continue[n])  state_nxt = WAIT_CONT;
            else if (ap_start[n]) state_nxt = BUSY;
            else                  state_nxt = IDLE;
          end
        end
        WAIT_CONT: if (ap_continue[n]) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset || clear) begin
        state     <= IDLE;
        lat_cnt   <= '0;
        start_cnt <= '0;
        done_cnt  <= '0;
        busy_cnt  <= '0;
        stall_cnt <= '0;
        iter_cnt  <= '0;
        max_lat   <= '0;
        last_lat  <= '0;
        err       <= 1'b0;
      end else if (!frozen) begin
        state <= state_nxt;
        if (ap_start[n] && ap_ready[n])
          start_cnt <= sat_inc(start_cnt);
        // A done while IDLE is a protocol error and is not counted.
        if (ap_done[n] && ap_continue[n] && state != IDLE)
          done_cnt <= sat_inc(done_cnt);
        // The start cycle counts as busy so busy_cnt sums run latencies.
        if (state == BUSY || (state == IDLE && ap_start[n]))
          busy_cnt <= sat_inc(busy_cnt);
        if (state == WAIT_CONT)
          stall_cnt <= sat_inc(stall_cnt);
        if (iter_end[n])
          iter_cnt <= sat_inc(iter_cnt);
        if (state == IDLE && ap_done[n])
          err <= 1'b1;
        if (state == IDLE && ap_start[n]) begin
          lat_cnt <= CNT_W'(1);
        end else if (state == BUSY) begin
          if (capture) begin
            last_lat <= lat_inc;
            if (lat_inc > max_lat) max_lat <= lat_inc;
            if (state_nxt == BUSY) lat_cnt <= CNT_W'(1);
          end else begin
            lat_cnt <= lat_inc;
          end
        end
      end
    end

    assign ch_state[2*n +: 2] = state;
    assign f_start[n] = start_cnt;
    assign f_done[n]  = done_cnt;
    assign f_busy[n]  = busy_cnt;
    assign f_stall[n] = stall_cnt;
    assign f_iter[n]  = iter_cnt;
    assign f_max[n]   = max_lat;
    assign f_last[n]  = last_lat;
    assign f_state[n] = state;
    assign f_err[n]   = err;
  end

  // Readout: channel compare in 32 bits so unused rd_ch codes select nothing.
  logic [31:0]      rd_ch_ext;
  logic [CNT_W-1:0] rd_mux;

  assign rd_ch_ext = 32'(rd_ch);

  always_comb begin
    rd_mux = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rd_ch_ext == c) begin
        case (rd_field)
          3'd0:    rd_mux = f_start[c];
          3'd1:    rd_mux = f_done[c];
          3'd2:    rd_mux = f_busy[c];
          3'd3:    rd_mux = f_stall[c];
          3'd4:    rd_mux = f_iter[c];
          3'd5:    rd_mux = f_max[c];
          3'd6:    rd_mux = f_last[c];
          default: rd_mux = CNT_W'({f_err[c], f_state[c]});
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_dataflow_perf_monitor.sv
module tb_dataflow_perf_monitor;

  localparam int F_START = 0, F_DONE = 1, F_BUSY = 2, F_STALL = 3;
  localparam int F_ITER = 4, F_MAX = 5, F_LAST = 6, F_STATUS = 7;

  logic clock = 1'b0;
  logic reset;

  // DUT A: default NUM_CH=4, CNT_W=32
  logic        finish_a, clear_a, rd_en_a, rd_valid_a, frozen_a;
  logic [3:0]  start_a, ready_a, done_a, cont_a, iter_a;
  logic [1:0]  rd_ch_a;
  logic [2:0]  rd_field_a;
  logic [31:0] rd_data_a;
  logic [7:0]  ch_state_a;

  // DUT B: NUM_CH=5, CNT_W=8
  logic        finish_b, clear_b, rd_en_b, rd_valid_b, frozen_b;
  logic [4:0]  start_b, ready_b, done_b, cont_b, iter_b;
  logic [2:0]  rd_ch_b;
  logic [2:0]  rd_field_b;
  logic [7:0]  rd_data_b;
  logic [9:0]  ch_state_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  dataflow_perf_monitor dut_a (
    .clock(clock), .reset(reset), .finish(finish_a), .clear(clear_a),
    .ap_start(start_a), .ap_ready(ready_a), .ap_done(done_a),
    .ap_continue(cont_a), .iter_end(iter_a),
    .rd_en(rd_en_a), .rd_ch(rd_ch_a), .rd_field(rd_field_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .frozen(frozen_a),
    .ch_state(ch_state_a)
  );

  dataflow_perf_monitor #(.NUM_CH(5), .CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .finish(finish_b), .clear(clear_b),
    .ap_start(start_b), .ap_ready(ready_b), .ap_done(done_b),
    .ap_continue(cont_b), .iter_end(iter_b),
    .rd_en(rd_en_b), .rd_ch(rd_ch_b), .rd_field(rd_field_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .frozen(frozen_b),
    .ch_state(ch_state_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic read_a(input int ch, input int fld, input string tag, input logic [63:0] exp);
    rd_en_a = 1'b1; rd_ch_a = 2'(ch); rd_field_a = 3'(fld);
    tick();
    check(tag, 64'(rd_data_a), exp);
    rd_en_a = 1'b0;
  endtask

  task automatic read_b(input int ch, input int fld, input string tag, input logic [63:0] exp);
    rd_en_b = 1'b1; rd_ch_b = 3'(ch); rd_field_b = 3'(fld);
    tick();
    check(tag, 64'(rd_data_b), exp);
    rd_en_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    finish_a = 0; clear_a = 0; rd_en_a = 0; rd_ch_a = 0; rd_field_a = 0;
    start_a = 0; ready_a = 0; done_a = 0; cont_a = 4'hF; iter_a = 0;
    finish_b = 0; clear_b = 0; rd_en_b = 0; rd_ch_b = 0; rd_field_b = 0;
    start_b = 0; ready_b = 0; done_b = 0; cont_b = 5'h1F; iter_b = 0;

    // Reset values before any clock edge
    #2;
    check("rst_rd_valid", 64'(rd_valid_a), 64'd0);
    check("rst_rd_data",  64'(rd_data_a),  64'd0);
    check("rst_frozen",   64'(frozen_a),   64'd0);
    check("rst_ch_state", 64'(ch_state_a), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Ch0: single run, done 5 cycles after start
    start_a[0] = 1; ready_a[0] = 1;
    tick();
    start_a[0] = 0; ready_a[0] = 0;
    check("ch0_busy_state", 64'(ch_state_a[1:0]), 64'd1);
    repeat (4) tick();
    done_a[0] = 1;
    tick();
    done_a[0] = 0;
    check("ch0_idle_state", 64'(ch_state_a[1:0]), 64'd0);
    read_a(0, F_START, "ch0_start_cnt", 64'd1);
    check("rd_valid_hi", 64'(rd_valid_a), 64'd1);
    read_a(0, F_DONE,  "ch0_done_cnt",  64'd1);
    read_a(0, F_LAST,  "ch0_last_lat",  64'd6);
    read_a(0, F_MAX,   "ch0_max_lat",   64'd6);
    read_a(0, F_BUSY,  "ch0_busy_cnt",  64'd6);
    tick();
    check("rd_valid_lo", 64'(rd_valid_a), 64'd0);

    // Ch1: done held with continue low for 3 cycles
    cont_a[1] = 0;
    start_a[1] = 1; ready_a[1] = 1;
    tick();
    start_a[1] = 0; ready_a[1] = 0;
    check("ch1_state_busy", 64'(ch_state_a[3:2]), 64'd1);
    tick();
    done_a[1] = 1;
    tick();
    check("ch1_state_wait", 64'(ch_state_a[3:2]), 64'd2);
    tick(); tick();
    cont_a[1] = 1;
    tick();
    done_a[1] = 0;
    check("ch1_state_idle", 64'(ch_state_a[3:2]), 64'd0);
    read_a(1, F_STALL, "ch1_stall_cnt", 64'd3);
    read_a(1, F_DONE,  "ch1_done_cnt",  64'd1);
    read_a(1, F_LAST,  "ch1_last_lat",  64'd3);
    read_a(1, F_BUSY,  "ch1_busy_cnt",  64'd3);

    // Ch2: done while IDLE sets err only
    done_a[2] = 1;
    tick();
    done_a[2] = 0;
    read_a(2, F_STATUS, "ch2_status_err", 64'd4);
    read_a(2, F_DONE,   "ch2_done_cnt",   64'd0);
    clear_a = 1;
    tick();
    clear_a = 0;
    read_a(2, F_STATUS, "ch2_status_clr", 64'd0);
    read_a(0, F_START,  "ch0_start_clr",  64'd0);
    read_a(0, F_MAX,    "ch0_max_clr",    64'd0);

    // Ch3: back-to-back runs, then a shorter run that must not lower max_lat
    start_a[3] = 1; ready_a[3] = 1;
    tick();
    start_a[3] = 0; ready_a[3] = 0;
    tick();
    done_a[3] = 1; start_a[3] = 1; ready_a[3] = 1;
    tick();
    done_a[3] = 0; start_a[3] = 0; ready_a[3] = 0;
    check("ch3_b2b_busy", 64'(ch_state_a[7:6]), 64'd1);
    tick(); tick();
    done_a[3] = 1;
    tick();
    done_a[3] = 0;
    start_a[3] = 1; ready_a[3] = 1;
    tick();
    start_a[3] = 0; ready_a[3] = 0; done_a[3] = 1;
    tick();
    done_a[3] = 0;
    read_a(3, F_START, "ch3_start_cnt", 64'd3);
    read_a(3, F_DONE,  "ch3_done_cnt",  64'd3);
    read_a(3, F_BUSY,  "ch3_busy_cnt",  64'd8);
    read_a(3, F_LAST,  "ch3_last_lat",  64'd2);
    read_a(3, F_MAX,   "ch3_max_lat",   64'd4);

    // Iteration pulses on ch0 only
    iter_a[0] = 1;
    repeat (3) tick();
    iter_a[0] = 0;
    read_a(0, F_ITER, "ch0_iter_cnt", 64'd3);
    read_a(1, F_ITER, "ch1_iter_cnt", 64'd0);

    // Freeze mid-run on ch0, then heavy activity that must be ignored
    start_a[0] = 1; ready_a[0] = 1;
    tick();
    start_a[0] = 0; ready_a[0] = 0;
    tick();
    finish_a = 1;
    tick();
    finish_a = 0;
    check("frozen_set", 64'(frozen_a), 64'd1);
    start_a = 4'hF; ready_a = 4'hF; done_a = 4'hF; iter_a = 4'hF;
    repeat (10) tick();
    start_a = 0; ready_a = 0; done_a = 0; iter_a = 0;
    check("frz_ch_state", 64'(ch_state_a), 64'h01);
    check("frz_frozen",   64'(frozen_a),   64'd1);
    read_a(0, F_START,  "frz_ch0_start", 64'd1);
    read_a(0, F_BUSY,   "frz_ch0_busy",  64'd3);
    read_a(0, F_DONE,   "frz_ch0_done",  64'd0);
    read_a(0, F_ITER,   "frz_ch0_iter",  64'd3);
    read_a(0, F_LAST,   "frz_ch0_last",  64'd0);
    read_a(2, F_STATUS, "frz_ch2_stat",  64'd0);
    read_a(3, F_START,  "frz_ch3_start", 64'd3);
    finish_a = 1; clear_a = 1;
    tick();
    finish_a = 0; clear_a = 0;
    check("clr_frozen",   64'(frozen_a),   64'd0);
    check("clr_ch_state", 64'(ch_state_a), 64'd0);

    // Async reset between clock edges during a run
    start_a[0] = 1; ready_a[0] = 1;
    tick();
    start_a[0] = 0; ready_a[0] = 0;
    read_a(0, F_START, "pre_rst_start", 64'd1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_ch_state", 64'(ch_state_a), 64'd0);
    check("arst_rd_data",  64'(rd_data_a),  64'd0);
    check("arst_rd_valid", 64'(rd_valid_a), 64'd0);
    #1;
    reset = 1'b0;
    repeat (3) tick();
    check("post_rst_state", 64'(ch_state_a), 64'd0);
    read_a(0, F_START, "post_rst_start", 64'd0);
    read_a(0, F_BUSY,  "post_rst_busy",  64'd0);
    read_a(0, F_LAST,  "post_rst_last",  64'd0);
    start_a[0] = 1; ready_a[0] = 1;
    tick();
    start_a[0] = 0; ready_a[0] = 0;
    check("post_rst_run", 64'(ch_state_a[1:0]), 64'd1);

    // DUT B: 8-bit saturation and out-of-range channel reads
    iter_b[0] = 1; start_b[1] = 1; ready_b[1] = 1;
    tick();
    start_b[1] = 0; ready_b[1] = 0;
    repeat (299) tick();
    iter_b[0] = 0;
    read_b(0, F_ITER,  "b_iter_sat",  64'd255);
    read_b(1, F_BUSY,  "b_busy_sat",  64'd255);
    done_b[1] = 1;
    tick();
    done_b[1] = 0;
    read_b(1, F_LAST,  "b_last_sat",  64'd255);
    read_b(1, F_MAX,   "b_max_sat",   64'd255);
    read_b(1, F_START, "b_start_cnt", 64'd1);
    iter_b[0] = 1;
    repeat (5) tick();
    iter_b[0] = 0;
    read_b(0, F_ITER,  "b_iter_hold", 64'd255);
    read_b(7, F_ITER,  "b_rdch7_data", 64'd0);
    check("b_rdch7_valid", 64'(rd_valid_b), 64'd1);
    read_b(5, F_START, "b_rdch5_data", 64'd0);
    read_b(4, F_STATUS, "b_ch4_status", 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
